// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding decode. Holds the PC, issues one word
// request at a time to instruction memory (req/gnt/rvalid) and presents the
// returned instruction with its PC to decode (valid/ready). A redirect from
// execute restarts fetch at a new target and discards any instruction that is
// in flight or being held.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   IFrst_i        asynchronous active-low reset
//   imem_req_o     instruction memory request
//   imem_addr_o    request address (current PC, word aligned)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response data valid
//   imem_rdata_i   response instruction word
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target (low two bits ignored)
//   instr_valid_o  instr_o/pc_o valid toward decode
//   instr_ready_i  decode accepts instruction
//   instr_o        fetched instruction
//   pc_o           PC of instr_o
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        IFrst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] redirect_tgt;

    // Targets are always word aligned; stray low bits are dropped.
    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i or negedge IFrst_i) begin
        if (!IFrst_i) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC & 32'hFFFF_FFFC;
            kill_q   <= 1'b0;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                end
            end

            REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    // A grant in the redirect cycle accepted the old address;
                    // its response must be thrown away.
                    if (imem_gnt_i) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    if (imem_rvalid_i) begin
                        // Response lands in the redirect cycle: drop it here,
                        // nothing stays outstanding.
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d  = imem_rdata_i;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (instr_ready_i) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = pc_q;
    // Valid is masked in a redirect cycle so decode never takes a stale
    // instruction, even with ready high.
    assign instr_valid_o = (state_q == HOLD) && !redirect_i;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i;
    logic        IFrst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .IFrst_i       (IFrst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: program-order PC of the next instruction decode should get.
    logic [31:0] exp_pc;
    int          stall_cnt;
    int          n_xfer;
    // Memory responder state.
    bit          pend;
    int          dly;
    logic [31:0] pend_addr;
    int          gnt_mode;
    int          rv_min, rv_max;
    // Outputs sampled in the last cycle.
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    bit          seen_dead;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0050_0093;
        if (a == 32'h0000_000C) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: entered just after a falling edge, drives inputs,
    // samples outputs, checks them against the reference and advances it.
    task automatic cyc(input bit rdr, input logic [31:0] rpc, input bit rdy);
        bit rv;
        bit gv;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        instr_ready_i = rdy;
        rv = pend && (dly == 0);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? memf(pend_addr) : $urandom();
        gv = imem_req_o && (gnt_mode == 0 || $urandom_range(0, 1) == 1);
        imem_gnt_i = gv;
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = instr_valid_o;
        s_instr = instr_o;
        s_pc    = pc_o;
        if (s_valid && s_instr == 32'hDEAD_BEEF) seen_dead = 1'b1;

        if (IFrst_i) begin
            if (rdr) chk("valid_in_redirect", {31'b0, s_valid}, 32'd0);
            if (s_valid) begin
                chk("pc_o", s_pc, exp_pc);
                chk("instr_o", s_instr, memf(exp_pc));
            end
            if (s_req && !rdr) chk("req_addr", s_addr, exp_pc);
        end

        if (!IFrst_i) begin
            exp_pc    = RESET_PC;
            stall_cnt = 0;
        end else begin
            if (s_valid && rdy) begin
                exp_pc    = exp_pc + 32'd4;
                n_xfer++;
                stall_cnt = 0;
            end else begin
                stall_cnt++;
            end
            if (rdr) begin
                exp_pc    = rpc & 32'hFFFF_FFFC;
                stall_cnt = 0;
            end
        end
        checks++;
        assert (stall_cnt < 200) else begin
            errors++;
            $error("FAIL liveness observed=%0d idle cycles expected=<200", stall_cnt);
            stall_cnt = 0;
        end

        if (rv) pend = 1'b0;
        else if (pend) dly--;
        if (gv) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            dly       = $urandom_range(rv_min, rv_max);
        end
        @(negedge clk_i);
    endtask

    initial begin
        IFrst_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        exp_pc = RESET_PC; stall_cnt = 0; n_xfer = 0;
        pend = 1'b0; dly = 0; pend_addr = 32'h0;
        gnt_mode = 0; rv_min = 0; rv_max = 0; seen_dead = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        @(negedge clk_i);
        IFrst_i = 1'b1;

        // Sequential fetch after reset release
        cyc(0, 0, 1); chk("t1_idle_req", {31'b0, s_req}, 32'd0);
        cyc(0, 0, 1); chk("t1_req0", {31'b0, s_req}, 32'd1); chk("t1_addr0", s_addr, 32'h0);
        cyc(0, 0, 1); chk("t1_wait_valid", {31'b0, s_valid}, 32'd0);
        cyc(0, 0, 1); chk("t1_first_valid", {31'b0, s_valid}, 32'd1); chk("t1_pc0", s_pc, 32'h0);
        cyc(0, 0, 1); chk("t1_addr4", s_addr, 32'h4);
        cyc(0, 0, 1);
        cyc(0, 0, 1); chk("t1_pc4", s_pc, 32'h4);
        cyc(0, 0, 1); chk("t1_addr8", s_addr, 32'h8);
        cyc(0, 0, 1);

        // Decode stall with instruction at 0x8 held
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            chk("t2_valid", {31'b0, s_valid}, 32'd1);
            chk("t2_pc", s_pc, 32'h8);
            chk("t2_instr", s_instr, 32'h0050_0093);
            chk("t2_req", {31'b0, s_req}, 32'd0);
        end
        rv_min = 2; rv_max = 2;
        cyc(0, 0, 1); chk("t2_xfer_pc", s_pc, 32'h8);
        cyc(0, 0, 1); chk("t2_next_addr", s_addr, 32'hC); chk("t2_next_req", {31'b0, s_req}, 32'd1);
        rv_min = 0; rv_max = 0;

        // Redirect in WAIT; late response for 0xC must be dropped
        seen_dead = 1'b0;
        cyc(1, 32'h100, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1); chk("t3_killed_req", {31'b0, s_req}, 32'd0);
        cyc(0, 0, 1); chk("t3_addr", s_addr, 32'h100); chk("t3_req", {31'b0, s_req}, 32'd1);
        cyc(0, 0, 1);
        // Redirect in HOLD with ready high: no transfer
        cyc(1, 32'h203, 1);
        chk("t4_valid_gated", {31'b0, s_valid}, 32'd0);
        chk("t3_pc_held", s_pc, 32'h100);
        chk("t3_no_dead", {31'b0, seen_dead}, 32'd0);
        cyc(0, 0, 1); chk("t4_addr", s_addr, 32'h200);
        cyc(0, 0, 1);
        cyc(0, 0, 1); chk("t4_pc", s_pc, 32'h200); chk("t4_valid", {31'b0, s_valid}, 32'd1);

        // Redirect in REQ with same-cycle grant, then PC wrap
        cyc(1, 32'hFFFF_FFFC, 1); chk("t5_old_addr", s_addr, 32'h204);
        cyc(0, 0, 1); chk("t5_kill_valid", {31'b0, s_valid}, 32'd0);
        cyc(0, 0, 1); chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 1);
        cyc(0, 0, 1); chk("t5_pc_top", s_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 1); chk("t5_addr_wrap", s_addr, 32'h0);
        cyc(0, 0, 1);
        cyc(0, 0, 1); chk("t5_pc_wrap", s_pc, 32'h0);

        // Asynchronous reset in the middle of WAIT
        rv_min = 3; rv_max = 3;
        cyc(0, 0, 1); chk("t6_addr", s_addr, 32'h4);
        rv_min = 0; rv_max = 0;
        cyc(0, 0, 1);
        IFrst_i = 1'b0;
        #1;
        chk("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("t6_rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("t6_rst_instr", instr_o, 32'd0);
        chk("t6_rst_pc", pc_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            chk("t6_in_rst_valid", {31'b0, s_valid}, 32'd0);
            chk("t6_in_rst_req", {31'b0, s_req}, 32'd0);
        end
        IFrst_i = 1'b1;
        cyc(0, 0, 1); chk("t6_idle", {31'b0, s_req}, 32'd0);
        cyc(0, 0, 1); chk("t6_restart_addr", s_addr, RESET_PC); chk("t6_restart_req", {31'b0, s_req}, 32'd1);
        cyc(0, 0, 1); chk("t6_wait_valid", {31'b0, s_valid}, 32'd0);
        cyc(0, 0, 1); chk("t6_pc", s_pc, RESET_PC); chk("t6_instr", s_instr, memf(RESET_PC));

        // Randomized traffic against the reference
        gnt_mode = 1; rv_min = 0; rv_max = 3;
        n_xfer = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 3) != 0);
            t  = $urandom();
            if ($urandom_range(0, 3) == 0) t = t | 32'hFFFF_FFF0;
            cyc(r, t, rd);
        end
        chk("rand_progress", {31'b0, (n_xfer >= 150)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the decode unit. Holds the PC, issues single-outstanding word requests to instruction memory over a req/gnt/rvalid handshake, and presents each fetched 32-bit instruction plus its PC to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) from execute and flushes any in-flight or held instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk_i  input  1  clock, all state on rising edge
IFrst_i  input  1  asynchronous active-low reset
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address (= PC, word aligned)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  response instruction word
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  redirect target
instr_valid_o  output  1  instr_o/pc_o valid toward decode
instr_ready_i  input  1  decode accepts instruction
instr_o  output  32  fetched instruction (feeds decode instr_i)
pc_o  output  32  PC of instr_o

Behaviour:
- Reset (IFrst_i=0, asynchronous): state=IDLE, pc=RESET_PC, kill=0, imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0. Takes effect immediately, mid-transaction included; rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: -> REQ next cycle (first request one cycle after reset release).
- REQ: imem_req_o=1, imem_addr_o=pc. gnt=1 -> WAIT. Address may change while gnt=0 (redirect only). rvalid ignored.
- WAIT: imem_req_o=0. rvalid=1 and kill=0 -> latch instr_o=rdata, pc_o=pc, pc<=pc+4, -> HOLD. rvalid=1 and kill=1 -> discard data, kill<=0, -> REQ.
- HOLD: instr_valid_o=1 (combinationally gated, see redirect). valid&ready -> REQ. instr_o/pc_o held stable while valid&!ready.
- Latency: gnt in cycle N, rvalid earliest N+1, instr_valid_o high cycle after rvalid. Max one outstanding request; rdata consumed only in WAIT.
- PC arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000). redirect_pc_i[1:0] forced to 00.
- Redirect (redirect_i=1), highest priority in all states:
  - IDLE/REQ: pc<=redirect_pc; stay/enter REQ; a gnt in that same cycle is for the old address -> enter WAIT with kill=1.
  - WAIT: pc<=redirect_pc; kill<=1 unless rvalid same cycle (then response discarded, -> REQ, kill stays 0).
  - HOLD: instr_valid_o forced 0 that cycle (no transfer even if ready=1); pc<=redirect_pc; -> REQ.
- Back-to-back redirects: last one wins; at most one kill pending.
- imem_addr_o driven = pc in all states; only meaningful with imem_req_o.

Test Plan:
- Reset release, RESET_PC=0, gnt tied 1, rvalid one cycle after gnt, ready=1 -> requests at 0x0,0x4,0x8; pc_o sequence 0,4,8 with matching instr_o; instr_valid_o first high 3 cycles after reset release.
- Decode stall: ready=0 for 5 cycles with instr 0x00500093 at pc 0x8 held -> instr_valid_o stays 1, instr_o/pc_o unchanged, imem_req_o=0 throughout; ready=1 -> one transfer, next request addr 0xC.
- Redirect in WAIT to 0x100, rvalid 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never presented; next request addr 0x100; pc_o=0x100.
- Redirect in HOLD with ready=1 same cycle, target 0x203 -> no transfer that cycle, next request addr 0x200.
- PC wrap: redirect to 0xFFFFFFFC -> fetch at 0xFFFFFFFC then 0x00000000.
- Async reset asserted mid-WAIT, rvalid arrives during reset -> outputs zero immediately, response ignored, fetch restarts at RESET_PC after release.
